// File: rtl/wb_stage.sv
// MEM/WB pipeline register and write-back driver for the 16-bit register file and the T flag.
// Optional retire counter output is enabled by defining WB_RETIRE_COUNTER_EN.
module wb_stage #(
  parameter logic [3:0] MAX_INDEX = 4'd10,
  parameter int         DATA_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              memValid,
  input  logic              memWriteReg,
  input  logic [3:0]        memWriteIndex,
  input  logic              memIsLoad,
  input  logic [DATA_W-1:0] memAluResult,
  input  logic [DATA_W-1:0] memReadData,
  input  logic              memWriteT,
  input  logic              memTValue,
  input  logic [3:0]        readIndexS,
  input  logic [3:0]        readIndexT,
  input  logic [3:0]        readIndexM,
  output logic              writeEnable,
  output logic [3:0]        writeIndex,
  output logic [DATA_W-1:0] dataToWrite,
  output logic              tWriteEnable,
  output logic              tToWrite,
  output logic              fwdHitS,
  output logic              fwdHitT,
  output logic              fwdHitM,
  output logic [DATA_W-1:0] fwdData,
  output logic              tFwdHit,
  output logic              badIndex
`ifdef WB_RETIRE_COUNTER_EN
  ,
  output logic [15:0]       retireCount
`endif
);

  function automatic logic is_legal(input logic [3:0] idx);
    return idx <= MAX_INDEX;
  endfunction

  logic              valid_p0;
  logic              write_reg_p0;
  logic [3:0]        index_p0;
  logic              is_load_p0;
  logic [DATA_W-1:0] alu_p0;
  logic [DATA_W-1:0] read_data_p0;
  logic              write_t_p0;
  logic              t_value_p0;
  logic              load_p0;

  assign load_p0 = !flush && !stall;

  // MEM -> WB latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_p0     <= 1'b0;
      write_reg_p0 <= 1'b0;
      index_p0     <= 4'd0;
      is_load_p0   <= 1'b0;
      alu_p0       <= '0;
      read_data_p0 <= '0;
      write_t_p0   <= 1'b0;
      t_value_p0   <= 1'b0;
      badIndex     <= 1'b0;
    end else if (flush) begin
      valid_p0 <= 1'b0;
    end else if (!stall) begin
      valid_p0     <= memValid;
      write_reg_p0 <= memWriteReg;
      index_p0     <= memWriteIndex;
      is_load_p0   <= memIsLoad;
      alu_p0       <= memAluResult;
      read_data_p0 <= memReadData;
      write_t_p0   <= memWriteT;
      t_value_p0   <= memTValue;
      if (memValid && memWriteReg && !is_legal(memWriteIndex))
        badIndex <= 1'b1;
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      retireCount <= 16'd0;
    else if (load_p0 && memValid)
      retireCount <= retireCount + 16'd1;
  end
`endif

  // WB drive: combinational from the latch, sampled by the register file on negedge
  logic gpr_commit;
  logic t_commit;

  assign gpr_commit   = valid_p0 && write_reg_p0 && is_legal(index_p0);
  assign t_commit     = valid_p0 && write_t_p0;

  assign dataToWrite  = is_load_p0 ? read_data_p0 : alu_p0;
  assign writeEnable  = !gpr_commit;
  assign writeIndex   = index_p0;
  assign tWriteEnable = !t_commit;
  assign tToWrite     = t_value_p0;

  assign fwdHitS      = gpr_commit && (index_p0 == readIndexS);
  assign fwdHitT      = gpr_commit && (index_p0 == readIndexT);
  assign fwdHitM      = gpr_commit && (index_p0 == readIndexM);
  assign fwdData      = dataToWrite;
  assign tFwdHit      = t_commit;

  logic unused_load;
  assign unused_load = load_p0;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a behavioural write-back model.
module tb_wb_stage;
  localparam logic [3:0] MAXI = 4'd10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        memValid = 1'b0, memWriteReg = 1'b0, memIsLoad = 1'b0;
  logic        memWriteT = 1'b0, memTValue = 1'b0;
  logic [3:0]  memWriteIndex = 4'd0;
  logic [15:0] memAluResult = 16'd0, memReadData = 16'd0;
  logic [3:0]  readIndexS = 4'd0, readIndexT = 4'd0, readIndexM = 4'd0;
  logic        writeEnable, tWriteEnable, tToWrite;
  logic [3:0]  writeIndex;
  logic [15:0] dataToWrite, fwdData;
  logic        fwdHitS, fwdHitT, fwdHitM, tFwdHit, badIndex;
`ifdef WB_RETIRE_COUNTER_EN
  logic [15:0] retireCount;
`endif

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .memValid(memValid), .memWriteReg(memWriteReg), .memWriteIndex(memWriteIndex),
    .memIsLoad(memIsLoad), .memAluResult(memAluResult), .memReadData(memReadData),
    .memWriteT(memWriteT), .memTValue(memTValue),
    .readIndexS(readIndexS), .readIndexT(readIndexT), .readIndexM(readIndexM),
    .writeEnable(writeEnable), .writeIndex(writeIndex), .dataToWrite(dataToWrite),
    .tWriteEnable(tWriteEnable), .tToWrite(tToWrite),
    .fwdHitS(fwdHitS), .fwdHitT(fwdHitT), .fwdHitM(fwdHitM),
    .fwdData(fwdData), .tFwdHit(tFwdHit), .badIndex(badIndex)
`ifdef WB_RETIRE_COUNTER_EN
    , .retireCount(retireCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: the instruction currently sitting in write-back, plus two register files
  logic        m_valid, m_wr, m_ld, m_wt, m_tv, m_bad;
  logic [3:0]  m_idx;
  logic [15:0] m_alu, m_rd;
  int          m_cnt;
  logic [15:0] rf_obs [16];
  logic [15:0] rf_mod [16];
  logic        t_obs, t_mod;

  task automatic model_reset();
    m_valid = 0; m_wr = 0; m_ld = 0; m_wt = 0; m_tv = 0; m_bad = 0;
    m_idx = 0; m_alu = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic model_clock();
    if (flush) m_valid = 0;
    else if (!stall) begin
      m_valid = memValid; m_wr = memWriteReg; m_idx = memWriteIndex; m_ld = memIsLoad;
      m_alu = memAluResult; m_rd = memReadData; m_wt = memWriteT; m_tv = memTValue;
      if (memValid && memWriteReg && memWriteIndex > MAXI) m_bad = 1;
      if (memValid) m_cnt = (m_cnt + 1) % 65536;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] d;
    logic gw, tw;
    d  = m_ld ? m_rd : m_alu;
    gw = m_valid && m_wr && (m_idx <= MAXI);
    tw = m_valid && m_wt;
    chk("writeEnable", writeEnable, !gw);
    chk("tWriteEnable", tWriteEnable, !tw);
    chk("fwdHitS", fwdHitS, gw && (m_idx == readIndexS));
    chk("fwdHitT", fwdHitT, gw && (m_idx == readIndexT));
    chk("fwdHitM", fwdHitM, gw && (m_idx == readIndexM));
    chk("tFwdHit", tFwdHit, tw);
    chk("badIndex", badIndex, m_bad);
    if (gw) begin
      chk("writeIndex", writeIndex, m_idx);
      chk("dataToWrite", dataToWrite, d);
      chk("fwdData", fwdData, d);
    end
    if (tw) chk("tToWrite", tToWrite, m_tv);
`ifdef WB_RETIRE_COUNTER_EN
    chk("retireCount", retireCount, m_cnt[15:0]);
`endif
  endtask

  // One cycle: posedge latch, output check, negedge register-file write and readback
  task automatic step();
    logic [15:0] d;
    @(posedge clk);
    model_clock();
    #1 check_outputs();
    @(negedge clk);
    #1;
    if (!writeEnable) rf_obs[writeIndex] = dataToWrite;
    if (!tWriteEnable) t_obs = tToWrite;
    d = m_ld ? m_rd : m_alu;
    if (m_valid && m_wr && m_idx <= MAXI) rf_mod[m_idx] = d;
    if (m_valid && m_wt) t_mod = m_tv;
    chk("rf", rf_obs[m_idx], rf_mod[m_idx]);
    chk("tflag", t_obs, t_mod);
  endtask

  task automatic drive(input logic v, input logic wr, input logic [3:0] idx, input logic ld,
                       input logic [15:0] alu, input logic [15:0] rd, input logic wt, input logic tv);
    memValid = v; memWriteReg = wr; memWriteIndex = idx; memIsLoad = ld;
    memAluResult = alu; memReadData = rd; memWriteT = wt; memTValue = tv;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin rf_obs[i] = 16'h0; rf_mod[i] = 16'h0; end
    t_obs = 0; t_mod = 0;
    model_reset();

    // reset held with an active write presented
    drive(1, 1, 4'd3, 0, 16'hAAAA, 16'h5555, 1, 1);
    repeat (2) @(posedge clk);
    #2;
    chk("rst_we", writeEnable, 1);
    chk("rst_twe", tWriteEnable, 1);
    chk("rst_data", dataToWrite, 0);
    chk("rst_idx", writeIndex, 0);
    chk("rst_bad", badIndex, 0);
    chk("rst_thit", tFwdHit, 0);
    @(negedge clk);
    rst = 1;
    #1 chk("post_rst_we", writeEnable, 1);

    // ALU write
    drive(1, 1, 4'd3, 0, 16'h1234, 16'h0F0F, 0, 0);
    step();
    chk("alu_data", dataToWrite, 16'h1234);
    chk("alu_idx", writeIndex, 3);
    chk("alu_rf3", rf_obs[3], 16'h1234);

    // load write with forwarding
    drive(1, 1, 4'd9, 1, 16'h1111, 16'hBEEF, 0, 0);
    readIndexS = 9; readIndexT = 9; readIndexM = 2;
    step();
    chk("ld_hitS", fwdHitS, 1);
    chk("ld_hitM", fwdHitM, 0);
    chk("ld_fwd", fwdData, 16'hBEEF);

    // stall holds, flush beats stall
    drive(1, 1, 4'd5, 0, 16'h5555, 16'h0, 0, 0);
    step();
    stall = 1;
    drive(1, 1, 4'd7, 0, 16'h7777, 16'h0, 0, 0);
    step(); step();
    chk("stall_idx", writeIndex, 5);
    flush = 1;
    step();
    chk("flush_we", writeEnable, 1);
    stall = 0; flush = 0;

    // illegal index is suppressed and sticky
    drive(1, 1, 4'd12, 0, 16'hDEAD, 16'h0, 0, 0);
    step();
    chk("ill_we", writeEnable, 1);
    chk("ill_bad", badIndex, 1);
    drive(1, 1, 4'd1, 0, 16'h0101, 16'h0, 0, 0);
    step();
    chk("ill_sticky", badIndex, 1);

    // T-only write
    drive(1, 0, 4'd2, 0, 16'h0, 16'h0, 1, 1);
    step();
    chk("t_twe", tWriteEnable, 0);
    chk("t_val", tToWrite, 1);
    chk("t_we", writeEnable, 1);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
            1'($urandom), 16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0, 1'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 7) == 0);
      readIndexS = ($urandom_range(0, 1) == 0) ? memWriteIndex : 4'($urandom_range(0, 15));
      readIndexT = 4'($urandom_range(0, 15));
      readIndexM = ($urandom_range(0, 2) == 0) ? m_idx : 4'($urandom_range(0, 15));
      step();
    end
    stall = 0; flush = 0;

    // reset mid-operation discards the latched write
    drive(1, 1, 4'd4, 0, 16'h4444, 16'h0, 1, 0);
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst_we", writeEnable, 1);
    chk("mid_rst_twe", tWriteEnable, 1);
    chk("mid_rst_bad", badIndex, 0);
    model_reset();
    @(negedge clk);
    #1 chk("mid_rst_neg_we", writeEnable, 1);
    rst = 1;

    // three valid loads after reset
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 4'(k), 1, 16'h0, 16'($urandom), 0, 0);
      step();
    end
`ifdef WB_RETIRE_COUNTER_EN
    chk("retire3", retireCount, 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
